// File: rtl/gpo_route_matrix.sv
// Routes synchronised GPO input lines to registered output lines through a
// double-buffered per-output table (source select, invert, pass/stretch/force).
module gpo_route_matrix #(
    parameter  int unsigned N_IN        = 8,
    parameter  int unsigned N_OUT       = 10,
    parameter  int unsigned STRETCH_LEN = 16,
    localparam int unsigned ISEL_W      = $clog2(N_IN + 1),
    localparam int unsigned OIDX_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_IN-1:0]   in_lines,
    output logic [N_OUT-1:0]  out_lines,
    input  logic              cfg_wr,
    input  logic [OIDX_W-1:0] cfg_out_idx,
    input  logic [ISEL_W-1:0] cfg_in_sel,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_invert,
    input  logic              cfg_commit,
    output logic [ISEL_W+2:0] cfg_rd_data
);

    localparam int unsigned CNT_W = $clog2(STRETCH_LEN + 1);

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_STRETCH = 2'd1,
        MODE_FORCE0  = 2'd2,
        MODE_FORCE1  = 2'd3
    } mode_e;

    // Select value N_IN is the "constant 0" source used as the reset default.
    localparam logic [ISEL_W-1:0] SEL_NONE   = ISEL_W'(N_IN);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(STRETCH_LEN - 1);

    logic [N_IN-1:0]   sync1_q;
    logic [N_IN-1:0]   sync2_q;

    logic [ISEL_W-1:0] sh_sel_q   [N_OUT];
    mode_e             sh_mode_q  [N_OUT];
    logic [N_OUT-1:0]  sh_inv_q;
    logic [ISEL_W-1:0] act_sel_q  [N_OUT];
    mode_e             act_mode_q [N_OUT];
    logic [N_OUT-1:0]  act_inv_q;

    logic [N_OUT-1:0]  src;
    logic [N_OUT-1:0]  rise;
    logic [N_OUT-1:0]  src_prev_q;
    logic [N_OUT-1:0]  out_d;
    logic [N_OUT-1:0]  out_q;
    logic [CNT_W-1:0]  cnt_d      [N_OUT];
    logic [CNT_W-1:0]  cnt_q      [N_OUT];
    logic              mask_q;
    logic              wr_hit;

    assign wr_hit    = cfg_wr && (32'(cfg_out_idx) < N_OUT);
    assign out_lines = out_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_lines;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                sh_sel_q[k]  <= SEL_NONE;
                sh_mode_q[k] <= MODE_FORCE0;
            end
            sh_inv_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (wr_hit && (cfg_out_idx == OIDX_W'(k))) begin
                    sh_sel_q[k]  <= cfg_in_sel;
                    sh_mode_q[k] <= mode_e'(cfg_mode);
                    sh_inv_q[k]  <= cfg_invert;
                end
            end
        end
    end

    // Commit samples the shadow registers before any same-cycle write lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                act_sel_q[k]  <= SEL_NONE;
                act_mode_q[k] <= MODE_FORCE0;
            end
            act_inv_q <= '0;
        end else if (cfg_commit) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                act_sel_q[k]  <= sh_sel_q[k];
                act_mode_q[k] <= sh_mode_q[k];
            end
            act_inv_q <= sh_inv_q;
        end
    end

    always_comb begin
        cfg_rd_data = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (cfg_out_idx == OIDX_W'(k)) begin
                cfg_rd_data = {act_sel_q[k], act_mode_q[k], act_inv_q[k]};
            end
        end
    end

    always_comb begin
        src = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (act_sel_q[k] == ISEL_W'(i)) begin
                    src[k] = sync2_q[i];
                end
            end
            src[k] = src[k] ^ act_inv_q[k];
        end

        // No edge is taken in the cycle after a commit: a source switch is not a pulse.
        rise = src & ~src_prev_q & {N_OUT{~mask_q}};

        out_d = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cfg_commit) begin
                cnt_d[k] = '0;
            end else if (rise[k]) begin
                cnt_d[k] = CNT_RELOAD;
            end else if (cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end

            case (act_mode_q[k])
                MODE_PASS:    out_d[k] = src[k];
                MODE_STRETCH: out_d[k] = src[k] | (cnt_q[k] != '0);
                MODE_FORCE0:  out_d[k] = 1'b0;
                MODE_FORCE1:  out_d[k] = 1'b1;
                default:      out_d[k] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_prev_q <= '0;
            out_q      <= '0;
            mask_q     <= 1'b0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            src_prev_q <= src;
            out_q      <= out_d;
            mask_q     <= cfg_commit;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_gpo_route_matrix.sv
// Scoreboard bench for gpo_route_matrix: a windowed behavioural model predicts
// each cycle's out_lines, queued on stimulus and compared when the register updates.
module tb_gpo_route_matrix;

    localparam int N_IN   = 8;
    localparam int N_OUT  = 10;
    localparam int L      = 16;
    localparam int ISEL_W = 4;
    localparam int OIDX_W = 4;
    localparam int MAXC   = 4096;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N_IN-1:0]   in_lines;
    logic [N_OUT-1:0]  out_lines;
    logic              cfg_wr;
    logic [OIDX_W-1:0] cfg_out_idx;
    logic [ISEL_W-1:0] cfg_in_sel;
    logic [1:0]        cfg_mode;
    logic              cfg_invert;
    logic              cfg_commit;
    logic [ISEL_W+2:0] cfg_rd_data;

    always #20 clk = ~clk;

    gpo_route_matrix #(
        .N_IN(N_IN),
        .N_OUT(N_OUT),
        .STRETCH_LEN(L)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_lines(in_lines),
        .out_lines(out_lines),
        .cfg_wr(cfg_wr),
        .cfg_out_idx(cfg_out_idx),
        .cfg_in_sel(cfg_in_sel),
        .cfg_mode(cfg_mode),
        .cfg_invert(cfg_invert),
        .cfg_commit(cfg_commit),
        .cfg_rd_data(cfg_rd_data)
    );

    typedef struct {
        int               due;
        logic [N_OUT-1:0] val;
    } exp_t;

    exp_t             sb[$];
    int               m_sh_sel[N_OUT];
    int               m_sh_mode[N_OUT];
    logic             m_sh_inv[N_OUT];
    int               m_ac_sel[N_OUT];
    int               m_ac_mode[N_OUT];
    logic             m_ac_inv[N_OUT];
    logic [N_IN-1:0]  in_h[MAXC];
    logic [N_OUT-1:0] rise_h[MAXC];
    logic [N_OUT-1:0] prev_src;
    logic             commit_prev;
    int               last_commit;
    int               cyc;
    int               total = 0;
    int               bad = 0;
    int               hi_cnt;
    int               hi_bit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_OUT; k++) begin
            m_sh_sel[k]  = N_IN;
            m_sh_mode[k] = 2;
            m_sh_inv[k]  = 1'b0;
            m_ac_sel[k]  = N_IN;
            m_ac_mode[k] = 2;
            m_ac_inv[k]  = 1'b0;
        end
        prev_src    = '0;
        commit_prev = 1'b0;
        last_commit = -1000000;
        cyc         = -1;
        sb.delete();
    endtask

    // One clock cycle: compare the due prediction, then drive this cycle's
    // stimulus and predict the output for the next cycle.
    task automatic step(input logic [N_IN-1:0] din, input logic wr, input int idx,
                        input int sel, input int mode, input logic inv, input logic cm);
        logic [N_IN-1:0]  s;
        logic [N_OUT-1:0] src;
        logic [N_OUT-1:0] rise;
        logic [N_OUT-1:0] e;
        exp_t             x;
        int               lo;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got=%0d expected<%0d", cyc, MAXC);
            $fatal(1);
        end
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            check("out_lines", 32'(out_lines), 32'(x.val));
        end
        if (out_lines[hi_bit]) hi_cnt++;

        in_lines    = din;
        cfg_wr      = wr;
        cfg_out_idx = OIDX_W'(idx);
        cfg_in_sel  = ISEL_W'(sel);
        cfg_mode    = 2'(mode);
        cfg_invert  = inv;
        cfg_commit  = cm;

        in_h[cyc] = din;
        s = (cyc >= 2) ? in_h[cyc-2] : '0;
        for (int k = 0; k < N_OUT; k++) begin
            src[k] = ((m_ac_sel[k] < N_IN) ? s[m_ac_sel[k]] : 1'b0) ^ m_ac_inv[k];
        end
        rise = src & ~prev_src;
        if (commit_prev) rise = '0;
        rise_h[cyc] = rise;

        lo = cyc - L + 1;
        if (lo < last_commit + 1) lo = last_commit + 1;
        if (lo < 0) lo = 0;
        for (int k = 0; k < N_OUT; k++) begin
            case (m_ac_mode[k])
                0: e[k] = src[k];
                1: begin
                    e[k] = src[k];
                    for (int m = lo; m < cyc; m++) if (rise_h[m][k]) e[k] = 1'b1;
                end
                2: e[k] = 1'b0;
                default: e[k] = 1'b1;
            endcase
        end
        x.due = cyc + 1;
        x.val = e;
        sb.push_back(x);

        prev_src = src;
        if (cm) begin
            for (int k = 0; k < N_OUT; k++) begin
                m_ac_sel[k]  = m_sh_sel[k];
                m_ac_mode[k] = m_sh_mode[k];
                m_ac_inv[k]  = m_sh_inv[k];
            end
            last_commit = cyc;
        end
        if (wr && idx < N_OUT) begin
            m_sh_sel[idx]  = sel;
            m_sh_mode[idx] = mode;
            m_sh_inv[idx]  = inv;
        end
        commit_prev = cm;
    endtask

    task automatic idle(input int n, input logic [N_IN-1:0] din);
        repeat (n) step(din, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic commit(input logic [N_IN-1:0] din);
        step(din, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic check_rd(input string tag);
        for (int k = 0; k < N_OUT; k++) begin
            cfg_out_idx = OIDX_W'(k);
            #1;
            check(tag, 32'(cfg_rd_data),
                  32'({ISEL_W'(m_ac_sel[k]), 2'(m_ac_mode[k]), m_ac_inv[k]}));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rstn        = 1'b0;
        in_lines    = '0;
        cfg_wr      = 1'b0;
        cfg_out_idx = '0;
        cfg_in_sel  = '0;
        cfg_mode    = '0;
        cfg_invert  = 1'b0;
        cfg_commit  = 1'b0;
        hi_bit      = 2;
        hi_cnt      = 0;
        model_reset();
        #50;
        check("reset_out", 32'(out_lines), 32'h0);
        check_rd("reset_rd");
        @(negedge clk) rstn = 1'b1;

        // Pass on sel 3 with exact latency
        step(8'h00, 1'b1, 0, 3, 0, 1'b0, 1'b0);
        commit(8'h00);
        idle(3, 8'h00);
        idle(5, 8'h08);
        idle(4, 8'h00);
        idle(1, 8'h08);
        idle(6, 8'h00);

        // Stretch: single pulse, then retriggered pair
        step(8'h00, 1'b1, 2, 1, 1, 1'b0, 1'b0);
        commit(8'h00);
        idle(4, 8'h00);
        hi_bit = 2;
        hi_cnt = 0;
        idle(1, 8'h02);
        idle(25, 8'h00);
        check("stretch_single_len", 32'(hi_cnt), 32'd16);
        hi_cnt = 0;
        idle(1, 8'h02);
        idle(9, 8'h00);
        idle(1, 8'h02);
        idle(35, 8'h00);
        check("stretch_retrig_len", 32'(hi_cnt), 32'd26);

        // Shadow isolation until commit
        step(8'h01, 1'b1, 4, 0, 0, 1'b0, 1'b0);
        idle(5, 8'h01);
        check("shadow_no_effect", 32'(out_lines[4]), 32'h0);
        check_rd("shadow_rd");
        commit(8'h01);
        idle(3, 8'h01);
        check("commit_applies", 32'(out_lines[4]), 32'h1);

        // Out-of-range writes are dropped
        step(8'h01, 1'b1, N_OUT, 1, 3, 1'b1, 1'b0);
        step(8'h01, 1'b1, 15, 1, 3, 1'b1, 1'b0);
        idle(1, 8'h01);
        check_rd("oob_wr_rd");
        commit(8'h01);
        idle(2, 8'h01);
        check_rd("oob_commit_rd");

        // Write and commit in the same cycle
        step(8'h01, 1'b1, 5, 0, 3, 1'b0, 1'b1);
        idle(3, 8'h01);
        check_rd("wr_commit_rd");
        check("wr_commit_old", 32'(out_lines[5]), 32'h0);
        commit(8'h01);
        idle(3, 8'h01);
        check("second_commit", 32'(out_lines[5]), 32'h1);

        // Source switch in stretch mode leaves no tail
        step(8'h08, 1'b1, 6, 2, 1, 1'b0, 1'b0);
        commit(8'h08);
        idle(4, 8'h08);
        step(8'h08, 1'b1, 6, 3, 1, 1'b0, 1'b0);
        commit(8'h08);
        idle(6, 8'h08);
        check("switch_high", 32'(out_lines[6]), 32'h1);
        idle(6, 8'h00);
        check("switch_no_tail", 32'(out_lines[6]), 32'h0);

        // Inversion, including the constant-0 source
        step(8'h00, 1'b1, 8, 9, 0, 1'b1, 1'b0);
        step(8'h00, 1'b1, 9, 1, 0, 1'b1, 1'b0);
        commit(8'h00);
        for (int i = 0; i < 12; i++) idle(1, 8'($urandom));
        check("inv_const", 32'(out_lines[8]), 32'h1);

        // Random configuration and traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0)
                step(8'($urandom), 1'b1, $urandom_range(0, 11), $urandom_range(0, 9),
                     $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 11) == 0);
            else
                step(8'($urandom), 1'b0, 0, 0, 0, 1'b0, $urandom_range(0, 11) == 0);
        end
        idle(20, 8'h00);

        // Asynchronous reset mid-stretch
        step(8'h00, 1'b1, 3, 5, 1, 1'b0, 1'b0);
        commit(8'h00);
        idle(4, 8'h00);
        idle(1, 8'h20);
        idle(9, 8'h00);
        check("pre_reset_stretch", 32'(out_lines[3]), 32'h1);
        #3;
        rstn = 1'b0;
        #1;
        check("async_reset_out", 32'(out_lines), 32'h0);
        in_lines   = '0;
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        model_reset();
        check_rd("async_reset_rd");
        @(negedge clk) rstn = 1'b1;
        idle(6, 8'hFF);
        check("post_reset_out", 32'(out_lines), 32'h0);
        idle(2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
